// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel among N_REQ requesters.
// A grant is held for a whole message, released on an accepted last byte or an idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_data_valid,
  input  logic               tx_data_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNTW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  // Release decision is taken one cycle early so grant clears exactly IDLE_TIMEOUT cycles after valid drops.
  localparam logic [CNTW-1:0] TO_LAST = (IDLE_TIMEOUT > 0) ? CNTW'(IDLE_TIMEOUT - 1) : '0;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [7:0]        txd_q, txd_d;
  logic              txv_q, txv_d;
  logic              terr_q, terr_d;

  logic              can_load;
  logic              own_valid;
  logic              load;
  logic              found;
  logic [IDXW-1:0]   win;
  logic [IDXW-1:0]   cand;
  logic [IDXW-1:0]   rr_next;
  int unsigned       idx;

  assign can_load  = !txv_q || tx_data_ready;
  assign own_valid = req_valid[owner_q];
  assign load      = (state_q == S_BUSY) && own_valid && can_load;
  assign rr_next   = (owner_q == IDXW'(N_REQ - 1)) ? '0 : owner_q + IDXW'(1);

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx  = (32'(rr_q) + i) % N_REQ;
      cand = idx[IDXW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    terr_d  = 1'b0;

    if (load) begin
      txd_d = req_data[{owner_q, 3'b000} +: 8];
      txv_d = 1'b1;
    end else if (txv_q && tx_data_ready) begin
      txv_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d      = S_BUSY;
          owner_d      = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
        end
      end
      S_BUSY: begin
        if (load && req_last[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          rr_d    = rr_next;
          cnt_d   = '0;
        end else if (own_valid) begin
          cnt_d = '0;
        end else if (IDLE_TIMEOUT != 0) begin
          if (cnt_q == TO_LAST) begin
            state_d = S_IDLE;
            grant_d = '0;
            rr_d    = rr_next;
            cnt_d   = '0;
            terr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      terr_q  <= terr_d;
    end
  end

  assign req_ready     = ((state_q == S_BUSY) && can_load) ? grant_q : '0;
  assign tx_data       = txd_q;
  assign tx_data_valid = txv_q;
  assign grant         = grant_q;
  assign busy          = (state_q == S_BUSY);
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, message atomicity, backpressure,
// idle timeout and asynchronous reset, with hand-computed expectations.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (4),
    .IDLE_TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] d);
    req_data[8*i +: 8] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    req_data      = '0;
    tx_data_ready = 1'b1;
    #12;
    check("rst_grant", 32'(grant), 'h0);
    check("rst_busy", 32'(busy), 'h0);
    check("rst_txv", 32'(tx_data_valid), 'h0);
    check("rst_txd", 32'(tx_data), 'h0);
    check("rst_terr", 32'(timeout_err), 'h0);
    check("rst_ready", 32'(req_ready), 'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin: every requester sends 1-byte messages; owners 0,1,2,3,0 with an idle gap.
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = 32'hA3A2A1A0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c % 2 == 1) check("rr_grant", 32'(grant), 32'(1) << (((c - 1) / 2) % 4));
      else begin
        check("rr_gap", 32'(grant), 'h0);
        check("rr_byte", 32'(tx_data), 32'('hA0 + ((c / 2 - 1) % 4)));
      end
    end
    req_valid = '0;
    req_last  = '0;
    step();
    step();

    // Single requester: 41,42,43 on tx_data at cycles 2,3,4.
    req_valid = 4'b0010;
    set_byte(1, 8'h41);
    step();
    check("single_grant", 32'(grant), 'h2);
    check("single_busy", 32'(busy), 'h1);
    check("single_ready", 32'(req_ready), 'h2);
    check("single_txv_c1", 32'(tx_data_valid), 'h0);
    step();
    check("single_b0", 32'(tx_data), 'h41);
    check("single_txv_c2", 32'(tx_data_valid), 'h1);
    set_byte(1, 8'h42);
    step();
    check("single_b1", 32'(tx_data), 'h42);
    set_byte(1, 8'h43);
    req_last = 4'b0010;
    step();
    check("single_b2", 32'(tx_data), 'h43);
    check("single_rel_c4", 32'(grant), 'h0);
    req_valid = '0;
    req_last  = '0;
    step();
    check("single_rel_c5", 32'(grant), 'h0);
    check("single_drain", 32'(tx_data_valid), 'h0);

    // Atomicity: req0 4-byte message while req2 waits.
    step();
    req_valid = 4'b0001;
    set_byte(0, 8'hB0);
    step();
    check("atom_grant0", 32'(grant), 'h1);
    req_valid[2] = 1'b1;
    req_last[2]  = 1'b1;
    set_byte(2, 8'hC0);
    #1;
    check("atom_ready_c1", 32'(req_ready), 'h1);
    for (int b = 1; b <= 3; b++) begin
      step();
      check("atom_byte", 32'(tx_data), 32'('hB0 + b - 1));
      check("atom_ready", 32'(req_ready), 'h1);
      set_byte(0, 8'(8'hB0 + b));
      if (b == 3) req_last[0] = 1'b1;
    end
    step();
    check("atom_last", 32'(tx_data), 'hB3);
    check("atom_rel", 32'(grant), 'h0);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    step();
    check("atom_grant2", 32'(grant), 'h4);
    check("atom_ready2", 32'(req_ready), 'h4);
    step();
    check("atom_c0", 32'(tx_data), 'hC0);
    check("atom_rel2", 32'(grant), 'h0);
    req_valid = '0;
    req_last  = '0;
    step();

    // Backpressure: uart_tx not ready for 10 cycles mid-message.
    req_valid = 4'b0010;
    set_byte(1, 8'hD0);
    step();
    check("bp_grant", 32'(grant), 'h2);
    step();
    check("bp_d0", 32'(tx_data), 'hD0);
    set_byte(1, 8'hD1);
    step();
    check("bp_d1", 32'(tx_data), 'hD1);
    set_byte(1, 8'hD2);
    tx_data_ready = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", 32'(tx_data), 'hD1);
      check("bp_txv", 32'(tx_data_valid), 'h1);
      check("bp_ready", 32'(req_ready), 'h0);
      step();
    end
    check("bp_hold_end", 32'(tx_data), 'hD1);
    tx_data_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(req_ready), 'h2);
    step();
    check("bp_d2", 32'(tx_data), 'hD2);
    set_byte(1, 8'hD3);
    req_last = 4'b0010;
    step();
    check("bp_d3", 32'(tx_data), 'hD3);
    check("bp_rel", 32'(grant), 'h0);
    req_valid = '0;
    req_last  = '0;
    step();
    check("bp_drain", 32'(tx_data_valid), 'h0);

    // Timeout: req3 sends one byte without last and goes quiet; req0 pending.
    req_valid = 4'b1001;
    req_last  = 4'b0001;
    set_byte(3, 8'hE3);
    set_byte(0, 8'hF0);
    step();
    check("to_grant3", 32'(grant), 'h8);
    step();
    check("to_e3", 32'(tx_data), 'hE3);
    check("to_terr_c2", 32'(timeout_err), 'h0);
    req_valid[3] = 1'b0;
    for (int c = 3; c <= 9; c++) begin
      step();
      check("to_hold", 32'(grant), 'h8);
      check("to_terr_low", 32'(timeout_err), 'h0);
      if (c == 3) check("to_no_inject", 32'(tx_data_valid), 'h0);
    end
    step();
    check("to_pulse", 32'(timeout_err), 'h1);
    check("to_rel", 32'(grant), 'h0);
    check("to_busy", 32'(busy), 'h0);
    check("to_txv", 32'(tx_data_valid), 'h0);
    step();
    check("to_grant0", 32'(grant), 'h1);
    check("to_pulse_end", 32'(timeout_err), 'h0);

    // Reset mid-message: req2 owns with a byte stuck in the buffer.
    step();
    check("rm_f0", 32'(tx_data), 'hF0);
    check("rm_rel0", 32'(grant), 'h0);
    req_valid = 4'b0100;
    req_last  = '0;
    set_byte(2, 8'h5A);
    step();
    check("rm_grant2", 32'(grant), 'h4);
    step();
    check("rm_5a", 32'(tx_data), 'h5A);
    check("rm_txv_pre", 32'(tx_data_valid), 'h1);
    tx_data_ready = 1'b0;
    req_valid     = 4'b0101;
    #1;
    rst_n = 1'b0;
    #1;
    check("rm_txv", 32'(tx_data_valid), 'h0);
    check("rm_grant", 32'(grant), 'h0);
    check("rm_busy", 32'(busy), 'h0);
    check("rm_ready", 32'(req_ready), 'h0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    tx_data_ready = 1'b1;
    step();
    check("rm_rr0", 32'(grant), 'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
